seq_gen: RTL and testbench



---
 rtl/seq_gen_pkg.sv | 14 +
 rtl/seq_bit_timer.sv | 30 +++
 rtl/seq_gen.sv | 128 ++++++++++++
 tb/tb_seq_gen.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_gen_pkg.sv
// seq_gen shared types.
// FSM encoding and sent-count width.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SENT_W = 8;

endpackage

// File: rtl/seq_bit_timer.sv
// Bit-period divider for seq_gen.
// Free-runs while clr is low; tc marks the last cycle of a period.
module seq_bit_timer #(
  parameter int BIT_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tc
);

  localparam int DW = $clog2(BIT_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(BIT_DIV - 1);

  logic [DW-1:0] div_cnt;

  assign tc = !clr && (div_cnt == DIV_MAX);

  // period counter, wraps on terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clr || tc) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_gen.sv
// Serial test-sequence generator.
// Sends a latched pattern MSB-first, repeated rep+1 times.
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W   = 4,
  parameter int BIT_DIV = 25000000,
  parameter int REP_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_start,
  input  logic [PAT_W-1:0]  bm,
  input  logic [REP_W-1:0]  rep,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              busy,
  output logic              done,
  output logic [SENT_W-1:0] sent_cnt
);

  localparam int BW = $clog2(PAT_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(PAT_W - 1);

  state_t             state;
  logic               key_prev;
  logic               start;
  logic               tmr_clr;
  logic               tc;
  logic [PAT_W-1:0]   pat;
  logic [PAT_W-1:0]   shift_reg;
  logic [BW-1:0]      bit_cnt;
  logic [REP_W-1:0]   rep_left;

  assign start   = key_start && !key_prev;
  assign tmr_clr = !((state == SHIFT) || (state == GAP));

  seq_bit_timer #(
    .BIT_DIV (BIT_DIV)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .tc    (tc)
  );

  // key history; resets high so a held key is not a start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_prev <= 1'b1;
    end else begin
      key_prev <= key_start;
    end
  end

  // transmit FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat       <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      rep_left  <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sent_cnt  <= '0;
    end else begin
      ser_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            pat       <= bm;
            shift_reg <= bm;
            rep_left  <= rep;
            bit_cnt   <= '0;
            sent_cnt  <= '0;
            busy      <= 1'b1;
            ser_out   <= bm[PAT_W-1];
            ser_valid <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (tc) begin
            if (sent_cnt != '1) begin
              sent_cnt <= sent_cnt + 1'b1;
            end
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              ser_out <= 1'b0;
              if (rep_left == '0) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                rep_left  <= rep_left - 1'b1;
                shift_reg <= pat;
                state     <= GAP;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_reg << 1;
              ser_out   <= shift_reg[PAT_W-2];
              ser_valid <= 1'b1;
            end
          end
        end
        GAP: begin
          if (tc) begin
            ser_out   <= shift_reg[PAT_W-1];
            ser_valid <= 1'b1;
            state     <= SHIFT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen.
// Driver queues per-cycle expectations; monitor pops and compares.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_start;
  logic [3:0] bm;
  logic [1:0] rep;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;
  logic [7:0] sent_cnt;

  seq_gen #(
    .PAT_W   (4),
    .BIT_DIV (4),
    .REP_W   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_start (key_start),
    .bm        (bm),
    .rep       (rep),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done),
    .sent_cnt  (sent_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int   c;
    logic so;
    logic sv;
    logic bz;
    logic dn;
    int   sc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   dones = 0;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  // queue the expected waveform of one transmission started at t0
  task automatic expect_run(input logic [3:0] pat, input int nrep,
                            input int t0, input int exp_sent,
                            input int busy_len);
    int c;
    int n;
    c = t0 + 1;
    n = 0;
    for (int f = 0; f <= nrep; f++) begin
      for (int b = 0; b < 4; b++) begin
        for (int d = 0; d < 4; d++) begin
          q.push_back('{c, pat[3-b], (d == 0), 1'b1, 1'b0, n});
          c++;
        end
        n++;
      end
      if (f < nrep) begin
        for (int d = 0; d < 4; d++) begin
          q.push_back('{c, 1'b0, 1'b0, 1'b1, 1'b0, n});
          c++;
        end
      end
    end
    q.push_back('{t0 + busy_len + 1, 1'b0, 1'b0, 1'b0, 1'b1, exp_sent});
  endtask

  task automatic press(input logic [3:0] p, input logic [1:0] r,
                       output int t0);
    bm        = p;
    rep       = r;
    key_start = 1'b1;
    t0        = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  int t0, t1, t2, t3, t4;

  initial begin
    rst_n     = 1'b0;
    key_start = 1'b1;
    bm        = 4'b0000;
    rep       = 2'd0;

    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst_n) begin
            if (done) dones++;
            if (ser_valid || busy || done || ser_out) begin
              tests++;
              if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected: cyc=%0d out=%b vld=%b busy=%b done=%b, required idle",
                         cyc, ser_out, ser_valid, busy, done);
              end else begin
                e = q.pop_front();
                if (e.c != cyc || ser_out !== e.so || ser_valid !== e.sv ||
                    busy !== e.bz || done !== e.dn || sent_cnt !== 8'(e.sc)) begin
                  fails++;
                  $display("FAIL stream: cyc=%0d out=%b vld=%b busy=%b done=%b cnt=%0d, required cyc=%0d out=%b vld=%b busy=%b done=%b cnt=%0d",
                           cyc, ser_out, ser_valid, busy, done, sent_cnt,
                           e.c, e.so, e.sv, e.bz, e.dn, e.sc);
                end
              end
            end else if (q.size() != 0 && q[0].c <= cyc) begin
              tests++;
              fails++;
              $display("FAIL missing: cyc=%0d got idle, required out=%b vld=%b busy=%b done=%b",
                       cyc, q[0].so, q[0].sv, q[0].bz, q[0].dn);
              void'(q.pop_front());
            end
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ser_out", int'(ser_out), 0);
    chk("rst_ser_valid", int'(ser_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sent_cnt", int'(sent_cnt), 0);

    // key held across reset release: no start
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("held_key_busy", int'(busy), 0);
    key_start = 1'b0;
    @(negedge clk);

    // single frame 1011
    press(4'b1011, 2'd0, t0);
    expect_run(4'b1011, 0, t0, 4, 16);
    @(negedge clk);
    key_start = 1'b0;
    wait_until(t0 + 17);
    chk("done_at_T17", int'(done), 1);
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    chk("done_edge_ignored", int'(busy), 0);
    @(negedge clk);

    // three frames of 0110
    press(4'b0110, 2'd2, t1);
    expect_run(4'b0110, 2, t1, 12, 56);
    @(negedge clk);
    key_start = 1'b0;
    wait_until(t1 + 57);
    chk("rep_sent_cnt", int'(sent_cnt), 12);
    @(negedge clk);

    // start in first idle cycle; mid-frame re-press with new bm
    press(4'b1100, 2'd0, t2);
    expect_run(4'b1100, 0, t2, 4, 16);
    @(negedge clk);
    key_start = 1'b0;
    wait_until(t2 + 6);
    bm        = 4'b0011;
    rep       = 2'd3;
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    wait_until(t2 + 19);

    // abort by reset during second bit
    press(4'b1110, 2'd1, t3);
    expect_run(4'b1110, 1, t3, 8, 36);
    @(negedge clk);
    key_start = 1'b0;
    wait_until(t3 + 6);
    rst_n = 1'b0;
    #1;
    chk("abort_ser_out", int'(ser_out), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ser_valid", int'(ser_valid), 0);
    chk("abort_sent_cnt", int'(sent_cnt), 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // full frame after abort
    press(4'b1011, 2'd0, t4);
    expect_run(4'b1011, 0, t4, 4, 16);
    @(negedge clk);
    key_start = 1'b0;
    wait_until(t4 + 20);

    chk("done_count", dones, 4);
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
